// File: rtl/serial_cla_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_cla_add_ctrl
//
// Purpose: 32-bit add/subtract unit that reuses a single 4-bit carry-lookahead
// adder over eight consecutive cycles, one nibble per cycle, LSB nibble first.
// A start request latches the operands; the result is presented with a
// one-cycle done pulse nine cycles after the start edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin an operation (honoured in IDLE and DONE only)
//   sub        0: a + b + carry_in, 1: a - b (computed as a + ~b + 1)
//   a, b       32-bit operands
//   carry_in   carry into bit 0 (add mode only)
//   busy       high while nibbles are being processed
//   done       one-cycle result-valid pulse
//   sum        32-bit result (valid from done until the next operation)
//   carry_out  carry out of bit 31 (for subtract: 1 = no borrow)
//   overflow   signed overflow of the 32-bit result
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder: all internal carries come from the
// generate/propagate terms and the carry in, with no ripple between bits.
module four_bit_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = a[gi] & b[gi];
            assign p[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sum
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign cout = c[4];
endmodule

module serial_cla_add_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        carry_out,
    output logic        overflow
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [2:0]  idx_reg;
    logic [31:0] a_reg;       // latched operand A
    logic [31:0] b_reg;       // latched effective operand (b or ~b)
    logic        carry_reg;   // carry into the nibble being processed
    logic [31:0] sum_reg;
    logic        carry_out_reg;
    logic        overflow_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_s;
    logic        nib_cout;

    // Nibble idx occupies bits [4*idx+3 : 4*idx].
    assign nib_a = a_reg[{idx_reg, 2'b00} +: 4];
    assign nib_b = b_reg[{idx_reg, 2'b00} +: 4];

    four_bit_cla u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .s    (nib_s),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            idx_reg       <= 3'd0;
            a_reg         <= 32'd0;
            b_reg         <= 32'd0;
            carry_reg     <= 1'b0;
            sum_reg       <= 32'd0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b here and force
                        // the initial carry so the datapath only ever adds.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : carry_in;
                        idx_reg   <= 3'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately not examined here.
                    sum_reg[{idx_reg, 2'b00} +: 4] <= nib_s;
                    carry_reg <= nib_cout;
                    idx_reg   <= idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        carry_out_reg <= nib_cout;
                        // Same-sign operands yielding a different-sign result.
                        overflow_reg  <= (a_reg[31] == b_reg[31])
                                      && (nib_s[3] != a_reg[31]);
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_serial_cla_add_ctrl.sv
// Testbench for serial_cla_add_ctrl: directed corner cases plus random
// operations. The driver pushes the expected result (computed with plain
// wide arithmetic) into a scoreboard queue at issue time; a monitor on the
// falling edge pops and compares whenever done is seen, and also checks the
// start-to-done latency and the number of busy cycles.
module tb_serial_cla_add_ctrl;
    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;

    serial_cla_add_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        int          issue;   // falling-edge count when start was driven
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   neg_cnt = 0;
    int   busy_run = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    // Reference model from the arithmetic definition, not the datapath.
    function automatic exp_t model(logic [31:0] xa, logic [31:0] xb,
                                   logic xsub, logic xcin, string tag);
        exp_t   e;
        longint sa, sb_v, sres;
        longint ua, ub, ures;
        sa   = longint'($signed(xa));
        sb_v = longint'($signed(xb));
        ua   = longint'({32'd0, xa});
        ub   = longint'({32'd0, xb});
        if (xsub) begin
            sres = sa - sb_v;
            ures = ua - ub;
            e.co = (ua >= ub);
        end else begin
            sres = sa + sb_v + longint'(xcin);
            ures = ua + ub + longint'(xcin);
            e.co = (ures >= 64'sd4294967296);
        end
        e.sum   = ures[31:0];
        e.ov    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        e.issue = 0;
        e.tag   = tag;
        return e;
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        neg_cnt++;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_sum"}, sum, e.sum);
                    chk({e.tag, "_cout"}, {31'd0, carry_out}, {31'd0, e.co});
                    chk({e.tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ov});
                    chk({e.tag, "_latency"}, neg_cnt - e.issue, 32'd10);
                    chk({e.tag, "_busy_cycles"}, busy_run, 32'd8);
                    $display("op %s: sum=%h cout=%b ovf=%b (exp %h %b %b)",
                             e.tag, sum, carry_out, overflow, e.sum, e.co, e.ov);
                end
                busy_run = 0;
            end else if (sb.size() > 0 && neg_cnt > sb[0].issue + 10) begin
                e = sb.pop_front();
                chk({e.tag, "_done_timeout"}, 32'd0, 32'd1);
            end
        end
    end

    // Drive one start pulse just after a rising edge; returns after the
    // start (T0) edge with start deasserted.
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                         input logic xsub, input logic xcin, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        a = xa; b = xb; sub = xsub; carry_in = xcin; start = 1'b1;
        e = model(xa, xb, xsub, xcin, tag);
        e.issue = neg_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        carry_in = $urandom_range(0, 1);
    endtask

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                          input logic xsub, input logic xcin, input string tag);
        issue(xa, xb, xsub, xcin, tag);
        repeat (10) @(posedge clk);
    endtask

    initial begin
        exp_t e1, e2;
        int   c;
        reset = 1'b1; start = 1'b0; sub = 1'b0;
        a = 32'd0; b = 32'd0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", sum, 32'd0);
        chk("reset_flags", {28'd0, busy, done, carry_out, overflow}, 32'd0);
        reset = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, "add_basic");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, "carry_ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "signed_ovf");
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, "sub_borrow");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, "sub_ovf");
        run_op(32'h1234_5678, 32'h8000_0000, 1'b1, 1'b0, "sub_minint");

        // Back-to-back: start held high, operands changed mid-run.
        @(posedge clk);
        #1;
        a = 32'hDEAD_BEEF; b = 32'h0123_4567; sub = 1'b0; carry_in = 1'b1;
        start = 1'b1;
        c = neg_cnt;
        e1 = model(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, "b2b_first");
        e1.issue = c;
        sb.push_back(e1);
        @(posedge clk);               // T0
        repeat (3) @(posedge clk);    // T3
        #1;
        a = 32'h0000_1000; b = 32'h0000_2001; sub = 1'b1; carry_in = 1'b0;
        e2 = model(32'h0000_1000, 32'h0000_2001, 1'b1, 1'b0, "b2b_second");
        e2.issue = c + 9;             // latched on the DONE-cycle edge T9
        sb.push_back(e2);
        repeat (6) @(posedge clk);    // T9
        #1;
        start = 1'b0;
        a = 32'hFFFF_0000; b = 32'h0F0F_0F0F;
        repeat (11) @(posedge clk);
        chk("b2b_drained", sb.size(), 32'd0);

        // Reset at nibble edge T4, held for two cycles.
        issue(32'h0F0F_0F0F, 32'h1111_1111, 1'b0, 1'b0, "aborted");
        repeat (4) @(posedge clk);    // T4
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rst_mid_sum", sum, 32'd0);
        chk("rst_mid_flags", {28'd0, busy, done, carry_out, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(32'hAAAA_5555, 32'h5555_AAAB, 1'b0, 1'b0, "after_reset");

        // Random operations with gaps that include DONE-cycle restarts.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 3) ra = 32'hFFFF_FFFF;
            if (i % 5 == 2) rb = 32'h8000_0000;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $sformatf("rand%0d", i));
            repeat ($urandom_range(7, 10)) @(posedge clk);
        end

        repeat (12) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_cla_add_ctrl.md
SERIAL_CLA_ADD_CTRL -- requirements
Module: serial_cla_add_ctrl

Interface
REQ-001 Ports SHALL be, in order (name  direction  width  meaning):
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation.
- sub  input  1  0 = a+b+carry_in, 1 = a-b (a + ~b + 1; carry_in ignored).
- a  input  32  operand A.
- b  input  32  operand B.
- carry_in  input  1  carry into bit 0 (add mode only).
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.
- sum  output  32  result.
- carry_out  output  1  carry out of bit 31.
- overflow  output  1  signed overflow of the 32-bit result.
REQ-002 Parameters: none.
REQ-003 The block SHALL contain exactly one four_bit_cla instance, used as the only adder; it is time-shared across all eight nibbles.

Function
REQ-004 FSM states: IDLE, RUN, DONE; 3-bit nibble counter idx (0..7).
REQ-005 In IDLE or DONE, start=1 at a rising edge SHALL:
- latch a, the effective operand (b if sub=0, ~b if sub=1), and the effective carry (carry_in if sub=0, 1 if sub=1) into internal registers;
- clear idx to 0;
- move to RUN.
REQ-006 In RUN, each rising edge SHALL:
- write the CLA sum for nibble idx (operand bits [4*idx+3:4*idx], carry = stored carry) into sum[4*idx+3:4*idx];
- store the CLA carry_out as the carry for the next nibble;
- increment idx.
REQ-007 The edge processing idx=7 SHALL also load carry_out with the final carry and overflow with (A[31]==B'[31]) && (result[31]!=A[31]), where B' is the effective operand; the state SHALL then move to DONE.
REQ-008 Latency SHALL be: start edge T0, nibble edges T1..T8, done=1 for the single cycle following T8, exactly 9 cycles from start to done.
REQ-009 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-010 DONE SHALL last one cycle: the state moves to IDLE if start=0, or to RUN per REQ-005 if start=1 (back-to-back operation).
REQ-011 start while in RUN SHALL be ignored: no re-latch, no queuing, no change to the in-flight result.
REQ-012 Changes on a, b, sub, or carry_in after the start edge SHALL NOT affect the in-flight operation.
REQ-013 sum, carry_out, and overflow SHALL hold their values from done until the next operation writes them. During RUN, sum is partially updated; sum is defined as valid only when done=1 and afterwards in IDLE.
REQ-014 Arithmetic is modulo 2^32: carry_out is the raw carry of the effective addition. For sub=1, carry_out=1 means no borrow (a >= b unsigned).

Reset
REQ-015 reset=1 SHALL asynchronously force:
- state IDLE, idx=0;
- busy=0, done=0, sum=0, carry_out=0, overflow=0;
- all latched operand and carry registers to 0.
REQ-016 reset asserted mid-RUN SHALL abort the operation with no done pulse. After deassertion, the block SHALL accept start on the first rising edge where reset=0.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Add basic: a=0x0000_0005, b=0x0000_0003, sub=0, carry_in=0, start pulse -> done exactly 9 cycles later; sum=0x0000_0008, carry_out=0, overflow=0; busy high for 8 cycles.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, carry_in=1 -> sum=0x0000_0000, carry_out=1, overflow=0.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x8000_0000, carry_out=0, overflow=1.
- Subtract with borrow: a=0x0000_0003, b=0x0000_0005, sub=1 -> sum=0xFFFF_FFFE, carry_out=0, overflow=0. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, carry_out=1, overflow=1.
- Busy/back-to-back: start held high continuously with operands changed mid-RUN -> first result matches the operands latched at T0; the second operation starts on the DONE cycle; done pulses exactly 9 cycles apart.
- Reset mid-op: reset asserted at nibble edge T4, released 2 cycles later -> all outputs 0 immediately with no done pulse; a new start then completes correctly after 9 cycles.
